// File: rtl/param_sync_queue_if.sv
// Producer/consumer handshake bundle for param_sync_queue.
// The queue side uses the slave modport; the environment drives through master.
interface param_sync_queue_if #(
    parameter int p_data_width  = 32,
    parameter int p_num_entries = 6
);
    localparam int c_count_width = $clog2(p_num_entries + 1);

    logic                     w_val;
    logic                     w_rdy;
    logic [p_data_width-1:0]  w_msg;
    logic                     r_val;
    logic                     r_rdy;
    logic [p_data_width-1:0]  r_msg;
    logic [c_count_width-1:0] count;
    logic                     almost_full;

    modport master (
        output w_val, w_msg, r_rdy,
        input  w_rdy, r_val, r_msg, count, almost_full
    );

    modport slave (
        input  w_val, w_msg, r_rdy,
        output w_rdy, r_val, r_msg, count, almost_full
    );
endinterface

// File: rtl/param_sync_queue.sv
// Single-clock val/rdy queue of arbitrary depth with occupancy count,
// almost-full flag, synchronous flush and optional pipe/bypass behaviour.
module param_sync_queue #(
    parameter int p_data_width  = 32,
    parameter int p_num_entries = 6,
    parameter int p_almost_full = 4,
    parameter int p_pipe        = 0,
    parameter int p_bypass      = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    param_sync_queue_if.slave  q
);
    localparam int c_ptr_width   = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;
    localparam int c_count_width = $clog2(p_num_entries + 1);

    typedef logic [c_ptr_width-1:0]   ptr_t;
    typedef logic [c_count_width-1:0] cnt_t;

    localparam ptr_t c_last     = ptr_t'(p_num_entries - 1);
    localparam ptr_t c_ptr_one  = ptr_t'(1);
    localparam cnt_t c_full     = cnt_t'(p_num_entries);
    localparam cnt_t c_af_level = cnt_t'(p_almost_full);
    localparam cnt_t c_cnt_one  = cnt_t'(1);

    logic [p_data_width-1:0] mem_q [p_num_entries];

    ptr_t w_ptr_q, w_ptr_d;
    ptr_t r_ptr_q, r_ptr_d;
    cnt_t count_q, count_d;
    logic almost_full_q, almost_full_d;

    logic                    flush;
    logic                    full;
    logic                    empty;
    logic                    w_rdy;
    logic                    r_val;
    logic [p_data_width-1:0] r_msg;
    logic                    w_go;
    logic                    r_go;
    logic                    bypass_fire;
    logic                    mem_we;

    // Handshake outputs; flush forces both sides idle irrespective of mode.
    always_comb begin
        flush = !reset || clear;
        full  = (count_q == c_full);
        empty = (count_q == '0);
        w_rdy = 1'b0;
        r_val = 1'b0;
        if (!flush) begin
            w_rdy = !full  || ((p_pipe   != 0) && q.r_rdy);
            r_val = !empty || ((p_bypass != 0) && q.w_val);
        end
        r_msg       = ((p_bypass != 0) && empty) ? q.w_msg : mem_q[r_ptr_q];
        w_go        = q.w_val && w_rdy;
        r_go        = r_val && q.r_rdy;
        bypass_fire = (p_bypass != 0) && empty && w_go && r_go;
        mem_we      = w_go && !bypass_fire;
    end

    // Pointer, occupancy and flag next-state. A bypass firing leaves storage untouched.
    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        count_d = count_q;
        if (flush) begin
            w_ptr_d = '0;
            r_ptr_d = '0;
            count_d = '0;
        end else begin
            if (mem_we) begin
                w_ptr_d = (w_ptr_q == c_last) ? '0 : w_ptr_q + c_ptr_one;
            end
            if (r_go && !bypass_fire) begin
                r_ptr_d = (r_ptr_q == c_last) ? '0 : r_ptr_q + c_ptr_one;
            end
            if (w_go && !r_go) begin
                count_d = count_q + c_cnt_one;
            end else if (r_go && !w_go) begin
                count_d = count_q - c_cnt_one;
            end
        end
        almost_full_d = (count_d >= c_af_level);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            w_ptr_q       <= '0;
            r_ptr_q       <= '0;
            count_q       <= '0;
            almost_full_q <= 1'b0;
        end else begin
            w_ptr_q       <= w_ptr_d;
            r_ptr_q       <= r_ptr_d;
            count_q       <= count_d;
            almost_full_q <= almost_full_d;
        end
    end

    // Storage is deliberately not reset; each entry loads only when addressed.
    for (genvar gi = 0; gi < p_num_entries; gi++) begin : g_mem
        always_ff @(posedge clk) begin
            if (mem_we && (w_ptr_q == ptr_t'(gi))) begin
                mem_q[gi] <= q.w_msg;
            end
        end
    end

    assign q.w_rdy       = w_rdy;
    assign q.r_val       = r_val;
    assign q.r_msg       = r_msg;
    assign q.count       = count_q;
    assign q.almost_full = almost_full_q;

    a_count_bound: assert property (@(posedge clk) disable iff (!reset)
        count_q <= c_full);
    a_ptr_w_bound: assert property (@(posedge clk) disable iff (!reset)
        w_ptr_q <= c_last);
    a_ptr_r_bound: assert property (@(posedge clk) disable iff (!reset)
        r_ptr_q <= c_last);
endmodule

// File: tb/tb_param_sync_queue.sv
// Drives three queue configurations (plain depth 3, pipe depth 2, bypass depth 6)
// with shared directed + random stimulus; each has its own queue-based reference.
module tb_param_sync_queue;
    localparam int c_w = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic           clear;
    logic           w_val;
    logic           r_rdy;
    logic [c_w-1:0] w_msg;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int dut, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, dut, act, exp, $time);
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int D    = (gi == 0) ? 3 : (gi == 1) ? 2 : 6;
        localparam int AF   = (gi == 2) ? 4 : 2;
        localparam int PIPE = (gi == 1) ? 1 : 0;
        localparam int BYP  = (gi == 2) ? 1 : 0;

        param_sync_queue_if #(.p_data_width(c_w), .p_num_entries(D)) qif ();
        assign qif.w_val = w_val;
        assign qif.w_msg = w_msg;
        assign qif.r_rdy = r_rdy;

        param_sync_queue #(
            .p_data_width (c_w),
            .p_num_entries(D),
            .p_almost_full(AF),
            .p_pipe       (PIPE),
            .p_bypass     (BYP)
        ) u_dut (
            .clk  (clk),
            .reset(reset),
            .clear(clear),
            .q    (qif)
        );

        logic [c_w-1:0] sbq[$];
        logic armed = 1'b0;
        logic exp_wrdy, exp_rval, exp_af;
        int   exp_count;

        // Reference: occupancy is the queue length; acceptance follows from it.
        always @(posedge clk) begin
            int n;
            #2;
            n         = sbq.size();
            exp_count = n;
            exp_af    = (n >= AF);
            if (!reset || clear) begin
                exp_wrdy = 1'b0;
                exp_rval = 1'b0;
                sbq.delete();
            end else begin
                exp_wrdy = (n < D) || ((PIPE != 0) && r_rdy);
                exp_rval = (n > 0) || ((BYP != 0) && w_val);
                if (w_val && exp_wrdy) sbq.push_back(w_msg);
            end
            armed = 1'b1;
        end

        always @(negedge clk) begin
            if (armed) begin
                check("w_rdy", gi, 32'(qif.w_rdy), 32'(exp_wrdy));
                check("r_val", gi, 32'(qif.r_val), 32'(exp_rval));
                check("count", gi, 32'(qif.count), 32'(exp_count));
                check("almost_full", gi, 32'(qif.almost_full), 32'(exp_af));
                if (qif.r_val === 1'b1 && r_rdy) begin
                    if (sbq.size() == 0) begin
                        check("r_msg_unexpected", gi, 32'(qif.r_msg), 32'hFFFF_FFFF);
                    end else begin
                        check("r_msg", gi, 32'(qif.r_msg), 32'(sbq[0]));
                        $display("dut%0d dequeue msg=%0d expected=%0d left=%0d",
                                 gi, qif.r_msg, sbq[0], sbq.size() - 1);
                        void'(sbq.pop_front());
                    end
                end
            end
        end
    end

    task automatic step(input logic rs, input logic cl, input logic wv,
                        input logic [c_w-1:0] wm, input logic rr);
        @(posedge clk);
        #1;
        reset = rs;
        clear = cl;
        w_val = wv;
        w_msg = wm;
        r_rdy = rr;
    endtask

    task automatic drain(input int cycles);
        for (int k = 0; k < cycles; k++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic fill3(input logic [c_w-1:0] base);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1, base + c_w'(k), 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        clear = 1'b0;
        w_val = 1'b0;
        r_rdy = 1'b0;
        w_msg = '0;
        step(1'b0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 16'd55, 1'b1);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);

        // Fill to depth, offer a fourth, then drain in order.
        step(1'b1, 1'b0, 1'b1, 16'd10, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'd13, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'd18, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'd99, 1'b0);
        drain(8);

        // One-in-one-out across several pointer wraps.
        for (int i = 1; i <= 7; i++) begin
            step(1'b1, 1'b0, 1'b1, c_w'(i), 1'b0);
            step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        end
        drain(2);

        // Five enqueues, then single dequeues past the almost-full threshold.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, c_w'(40 + i), 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        drain(7);

        // Full with 21, 22 then simultaneous enqueue 23 / dequeue.
        step(1'b1, 1'b0, 1'b1, 16'd21, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'd22, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'd23, 1'b1);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        drain(7);

        // Pass-through while empty, then store with consumer stalled.
        step(1'b1, 1'b0, 1'b1, 16'd10, 1'b1);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 16'd10, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        drain(3);

        // Flush by clear, by reset, and by both, with handshakes offered.
        fill3(16'd100);
        step(1'b1, 1'b1, 1'b1, 16'd77, 1'b1);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        fill3(16'd200);
        step(1'b0, 1'b0, 1'b1, 16'd78, 1'b1);
        step(1'b1, 1'b0, 1'b0, '0, 1'b0);
        fill3(16'd300);
        step(1'b0, 1'b1, 1'b1, 16'd79, 1'b1);
        step(1'b1, 1'b0, 1'b0, '0, 1'b1);

        // Random traffic alternating between fill-biased and drain-biased phases.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(199, 0) != 0,
                 $urandom_range(59, 0) == 0,
                 $urandom_range(99, 0) < 60,
                 c_w'($urandom),
                 $urandom_range(99, 0) < (((i % 160) < 80) ? 30 : 80));
        end
        drain(8);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/param_sync_queue.md
# param_sync_queue

Single-clock, parametrised normal queue, the successor to the power-of-two bisynchronous queue used between source and sink blocks. It decouples a val/rdy producer from a val/rdy consumer running on the same clock. Compared with the earlier queue it adds:
- arbitrary (non-power-of-two) depth
- an occupancy count and an almost-full flag
- synchronous flush
- optional pipe and bypass modes

## Interface
Parameters:
- p_data_width, 32, message width in bits (≥1)
- p_num_entries, 6, queue depth; any integer ≥2
- p_almost_full, 4, almost_full asserts when count ≥ this value (1..p_num_entries)
- p_pipe, 0, 1 = w_rdy also high when full and a dequeue fires in the same cycle
- p_bypass, 0, 1 = when empty, w_msg passes combinationally to r_msg in the same cycle

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-low (0 = reset), sampled on posedge clk
- clear  in  1  synchronous flush; drops all entries
- w_val  in  1  enqueue valid
- w_rdy  out  1  enqueue ready
- w_msg  in  p_data_width  enqueue data
- r_val  out  1  dequeue valid
- r_rdy  in  1  dequeue ready
- r_msg  out  p_data_width  dequeue data
- count  out  $clog2(p_num_entries+1)  current occupancy
- almost_full  out  1  count ≥ p_almost_full

## Operation
- Storage: p_num_entries × p_data_width register array.
- Pointers: w_ptr and r_ptr, each $clog2(p_num_entries) bits. Each increments on its go signal and wraps from p_num_entries-1 to 0 (explicit compare, no power-of-two masking).
- Occupancy: a registered count distinguishes full from empty. full = (count == p_num_entries); empty = (count == 0).
- Go signals: w_go = w_val & w_rdy; r_go = r_val & r_rdy.
- Bypass firing: when p_bypass=1, empty and w_val & r_rdy, the message passes straight through. Pointers and count are unchanged and the mem write is suppressed.
- Base handshake:
  - w_rdy = !full
  - r_val = !empty
  - r_msg = mem[r_ptr]
- p_pipe=1: w_rdy = !full | r_rdy. When full, an enqueue is accepted only together with a dequeue.
- p_bypass=1: r_val = !empty | w_val; r_msg = empty ? w_msg : mem[r_ptr].
- Count update:
  - +1 on w_go only
  - −1 on r_go only
  - unchanged on both, or on a bypass firing
- Simultaneous w_go & r_go when not empty:
  - write mem[w_ptr] and advance both pointers
  - a full queue stays full (pipe mode)
  - a queue of one stays at one
- Priority: reset > clear > normal operation.
- reset=0 or clear=1: w_rdy=0 and r_val=0 that cycle, regardless of mode. Handshakes are ignored. Next state is w_ptr=r_ptr=0, count=0.
- Clear mid-stream discards all stored entries, including one that is being presented.
- mem contents are not reset; r_msg is don't-care while r_val=0.

## Timing
- Reset values (cycle after reset=0 sampled): count=0, almost_full=0, r_val=0. w_rdy=1 once reset=1 and clear=0.
- Enqueue→dequeue latency:
  - 1 cycle normally (r_val rises the cycle after w_go into an empty queue)
  - 0 cycles in bypass when empty
- w_rdy, r_val, r_msg are combinational from state. In pipe/bypass modes they additionally depend combinationally on r_rdy/w_val; the designer must avoid loops at the integration level.
- count and almost_full are registered, reflecting all go events of the previous cycle.
- Throughput: one enqueue and one dequeue per cycle sustained.

## Test plan
- Depth 3, width 16, no pipe/bypass. Enqueue 10, 13, 18 back-to-back with r_rdy=0:
  - count goes 1, 2, 3; w_rdy=0 after the third
  - a fourth w_val is not accepted
  - then r_rdy=1 dequeues 10, 13, 18 in order
  - count returns to 0; r_val=0
- Depth 3, non-power-of-two wrap: 7 enqueue/dequeue pairs of values 1..7, interleaved one-in-one-out:
  - outputs 1..7 in order
  - r_ptr and w_ptr each wrap 2→0 twice with no data corruption
- Depth 6, p_almost_full=4. Enqueue 5 items:
  - almost_full=0 at count 3
  - almost_full=1 at counts 4 and 5
  - one dequeue → count 4, still 1; second dequeue → count 3, 0
- Pipe mode, depth 2, full with 21, 22, w_val=1 msg 23, r_rdy=1:
  - w_rdy=1; 21 dequeued, 23 enqueued in the same cycle
  - count stays 2; next outputs are 22 then 23
- Bypass mode, empty, w_val=1 msg 10, r_rdy=1:
  - r_val=1 and r_msg=10 in the same cycle; count stays 0
  - with r_rdy=0 instead: 10 is stored and count=1 next cycle
- Holding state (3 entries), each case in turn:
  - clear=1 for one cycle: w_rdy=0 and r_val=0 that cycle; count=0 and r_val=0 the next cycle
  - same with reset=0: identical result
  - reset=0 and clear=1 together: reset behaviour
